// File: rtl/game_pkg.sv
// Shared game definitions: slot layout of colour sequences, controller state
// encodings and helpers for reading/writing individual colour slots.
package game_pkg;

  localparam int NUM_SLOTS = 5;
  localparam int COLOUR_W  = 3;
  localparam int SEQ_W     = NUM_SLOTS * COLOUR_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PASS    = 2'd2,
    FAIL    = 2'd3
  } game_state_t;

  typedef logic [COLOUR_W-1:0] colour_t;
  typedef logic [SEQ_W-1:0]    seq_t;

  // Slot 0 occupies the low bits and is the first colour of a round.
  function automatic colour_t slot_sel(input seq_t seq, input logic [2:0] idx);
    colour_t c;
    c = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idx == 3'(i)) c = seq[i*COLOUR_W +: COLOUR_W];
    end
    return c;
  endfunction

  function automatic seq_t slot_put(input seq_t seq, input logic [2:0] idx,
                                    input colour_t c);
    seq_t s;
    s = seq;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idx == 3'(i)) s[i*COLOUR_W +: COLOUR_W] = c;
    end
    return s;
  endfunction

  // Round lengths outside 1..NUM_SLOTS are pulled to the nearest legal value.
  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    logic [2:0] l;
    if (len == 3'd0)                   l = 3'd1;
    else if (len > 3'(NUM_SLOTS))      l = 3'(NUM_SLOTS);
    else                               l = len;
    return l;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for a debounced button level; one-cycle pulse per press.
module key_edge_detect (
  input  logic clock,
  input  logic Reset,
  input  logic level,
  output logic rise
);

  logic key_prev;

  always_ff @(posedge clock) begin
    if (Reset) key_prev <= 1'b0;
    else       key_prev <= level;
  end

  assign rise = level & ~key_prev;

endmodule

// File: rtl/player_sequence_checker.sv
// Collects the player's colour presses for one round, checks each against the
// latched expected sequence and reports pass, mismatch or inactivity timeout.
module player_sequence_checker
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int TIMER_W        = 26
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             start,
  input  logic [2:0]       round_len,
  input  logic [SEQ_W-1:0] expected,
  input  logic             key_valid,
  input  logic [2:0]       key_colour,
  output logic             busy,
  output logic [SEQ_W-1:0] entered,
  output logic [2:0]       count,
  output logic             success,
  output logic             fail,
  output logic             timeout,
  output logic             done
);

  game_state_t        state, state_n;
  seq_t               exp_q;
  logic [2:0]         len_q;
  logic [TIMER_W-1:0] timer;
  logic               press;
  logic               hit;
  logic               timer_expired;
  logic [2:0]         cnt_inc;

  key_edge_detect u_key_edge (
    .clock (clock),
    .Reset (Reset),
    .level (key_valid),
    .rise  (press)
  );

  assign hit           = (key_colour == slot_sel(exp_q, count));
  assign cnt_inc       = count + 3'd1;
  assign timer_expired = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  // Start overrides everything; within COLLECT a press beats a timeout.
  always_comb begin
    state_n = state;
    if (start) begin
      state_n = COLLECT;
    end else if (state == COLLECT) begin
      if (press) begin
        if (!hit)                 state_n = FAIL;
        else if (cnt_inc == len_q) state_n = PASS;
      end else if (timer_expired) begin
        state_n = FAIL;
      end
    end
  end

  always_comb begin
    busy    = 1'b0;
    success = 1'b0;
    fail    = 1'b0;
    case (state)
      COLLECT: busy    = 1'b1;
      PASS:    success = 1'b1;
      FAIL:    fail    = 1'b1;
      default: ;
    endcase
  end

  // Round parameters are only sampled on start, so no reset is needed here.
  always_ff @(posedge clock) begin
    if (start) begin
      exp_q <= expected;
      len_q <= clamp_len(round_len);
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      entered <= '0;
      count   <= '0;
      timer   <= '0;
      timeout <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        entered <= '0;
        count   <= '0;
        timer   <= '0;
        timeout <= 1'b0;
      end else if (state == COLLECT) begin
        if (press) begin
          entered <= slot_put(entered, count, key_colour);
          timer   <= '0;
          if (hit) count <= cnt_inc;
          done <= !hit || (cnt_inc == len_q);
        end else if (timer_expired) begin
          timeout <= 1'b1;
          done    <= 1'b1;
        end else begin
          timer <= timer + TIMER_W'(1);
        end
      end
    end
  end

endmodule
